aes_host_if: RTL and testbench
==============================

Name: aes_host_if

Overview:
Parametrised byte-serial host interface between the pad-ring signals (CMD, DIN, READY, OK, DOUT) and the AES core. It synchronises the asynchronous pad inputs and detects command strobes. It assembles BUS_W-wide beats into BLK_W-bit key/text blocks, hands them to the core, and buffers the result for beat-wise readout. It replaces direct pad-to-core wiring in the next chip revision.

Parameters:
BUS_W, 8, pad data bus width in bits; BLK_W must be an integer multiple of it.
BLK_W, 128, key/text/result block width in bits.
SYNC_STAGES, 2, flop stages on CMD and DIN (>=2).
N (localparam), BLK_W/BUS_W, beats per block; counter width is clog2(N).

Ports:
CLK  in  1  system clock
RST_  in  1  asynchronous active-low reset
CMD  in  2  host command from pad: 00 NOP, 01 LOAD_KEY, 10 LOAD_TEXT, 11 READ
DIN  in  BUS_W  host data beat from pad
READY  out  1  interface can accept LOAD_KEY/LOAD_TEXT
OK  out  1  result block available for READ
DOUT  out  BUS_W  result beat to pad
core_key  out  BLK_W  assembled key
core_key_vld  out  1  one-cycle strobe: core_key valid
core_text  out  BLK_W  assembled plaintext/ciphertext
core_text_vld  out  1  one-cycle strobe: core_text valid
core_ready  in  1  core can accept a text block
core_res  in  BLK_W  core result
core_res_vld  in  1  one-cycle strobe: core_res valid

Behaviour:
- Reset: CLK single domain; RST_ asynchronous active-low. All state clears: FSM IDLE, counters 0, shift registers 0, sync flops 0. Outputs at reset: READY=1, OK=0, DOUT=0, core_key=0, core_text=0, both vld=0.
- Sync: CMD and DIN each pass through SYNC_STAGES flops (cmd_s, din_s).
- Strobe: a command fires on the single cycle where cmd_s!=00 and the previous cmd_s==00. A held command fires once only. The host must return CMD to 00 between beats and must hold DIN stable while CMD is non-zero. Pad-to-action latency is SYNC_STAGES+1 cycles.
- Beat order: MSB-first for all blocks. A load shifts left, with din_s entering the LSBs. READ presents the top BUS_W bits of the result register, then shifts it left.
- FSM IDLE (READY=1, OK=0):
  - LOAD_KEY: shift into key_sr and increment beat_cnt. On beat N-1, copy key_sr to core_key, pulse core_key_vld for 1 cycle, clear beat_cnt, stay in IDLE.
  - LOAD_TEXT: handled the same way into text_sr. On beat N-1, copy text_sr to core_text and go to PEND.
  - Type switch: if a LOAD type differs from the partial block in progress (beat_cnt!=0), discard the partial block. The new beat becomes beat 0 of the new type.
  - READ and NOP are ignored in IDLE.
- FSM PEND (READY=0): wait for core_ready=1. On that cycle pulse core_text_vld and go to BUSY. If core_ready is already 1 on entry, the pulse occurs on the first PEND cycle.
- FSM BUSY (READY=0): all commands ignored. On core_res_vld, latch core_res into res_sr, clear beat_cnt, go to RESULT, and set OK=1 in the next cycle.
- FSM RESULT (READY=0, OK=1):
  - READ: DOUT <= res_sr[BLK_W-1 -: BUS_W] (registered, updates 1 cycle after the strobe). Then shift res_sr and increment beat_cnt.
  - After the N-th READ: OK=0, READY=1, go to IDLE, beat_cnt=0.
  - LOAD commands are ignored in RESULT.
- DOUT holds its last value until the next READ.
- core_res_vld outside BUSY is ignored.
- The key persists across blocks: multiple text blocks may follow a single key load.
- Reset asserted mid-operation discards all partial blocks and results immediately (asynchronous). After RST_ deasserts, the first command requires a fresh 00-to-non-zero transition.

Test Plan:
- Key load: 16 LOAD_KEY beats 0x00..0x0F with NOP gaps -> single core_key_vld pulse, core_key=0x000102...0F. READY stays 1 throughout.
- Text with core stalled: core_ready=0, 16 LOAD_TEXT beats 0xA0..0xAF -> READY=0 and no core_text_vld. Raise core_ready after 5 cycles -> one core_text_vld pulse, core_text=0xA0A1...AF.
- Result readout: in BUSY, pulse core_res_vld with 0x112233...FF00 -> OK=1. 16 READs -> DOUT sequence 0x11,0x22,...,0xFF,0x00. After the last READ, OK=0 and READY=1.
- Held command: CMD=01 held for 20 cycles with DIN=0x5A -> exactly one beat accepted (beat_cnt=1).
- Type switch: 3 LOAD_KEY beats, then 16 LOAD_TEXT beats -> no core_key_vld. core_text contains only the 16 text beats.
- Reset mid-read: assert RST_=0 after the 7th READ -> OK=0, READY=1, DOUT=0 immediately. A subsequent READ is ignored.

Source files
------------

// File: rtl/aes_host_if_if.sv
// -----------------------------------------------------------------------------
// aes_host_if_if
// Bundles the pad-ring signals and the AES core signals of aes_host_if.
//   Pad side  : CMD, DIN (host -> block), READY, OK, DOUT (block -> host)
//   Core side : core_key/_vld and core_text/_vld (block -> core),
//               core_ready, core_res/_vld (core -> block)
// Modports:
//   slave  - the aes_host_if block itself
//   master - the environment (pads and core) around the block
//
// Handshake semantics, documented once:
//   * Pad commands are level-based. A command is taken on a 00 -> non-zero
//     transition of the synchronised CMD. The host returns CMD to 00 between
//     beats and holds DIN stable while CMD is non-zero.
//   * core_key_vld and core_text_vld are one-cycle strobes. core_text_vld is
//     issued only in a cycle after core_ready was sampled high, so the transfer
//     is a valid/ready pair where valid waits for ready.
//   * core_res_vld is a one-cycle strobe. It is honoured only while a result
//     is outstanding.
// -----------------------------------------------------------------------------
interface aes_host_if_if #(
  parameter int BUS_W = 8,
  parameter int BLK_W = 128
);
  logic [1:0]       CMD;
  logic [BUS_W-1:0] DIN;
  logic             READY;
  logic             OK;
  logic [BUS_W-1:0] DOUT;
  logic [BLK_W-1:0] core_key;
  logic             core_key_vld;
  logic [BLK_W-1:0] core_text;
  logic             core_text_vld;
  logic             core_ready;
  logic [BLK_W-1:0] core_res;
  logic             core_res_vld;

  modport slave (
    input  CMD, DIN, core_ready, core_res, core_res_vld,
    output READY, OK, DOUT, core_key, core_key_vld, core_text, core_text_vld
  );

  modport master (
    output CMD, DIN, core_ready, core_res, core_res_vld,
    input  READY, OK, DOUT, core_key, core_key_vld, core_text, core_text_vld
  );
endinterface

// File: rtl/aes_host_if.sv
// -----------------------------------------------------------------------------
// aes_host_if
// Byte-serial host interface between the pad ring and the AES core.
// CMD and DIN are synchronised, and command strobes are detected on them.
// BUS_W beats are assembled MSB-first into BLK_W key/text blocks for the core.
// The core result is buffered and read back one beat per READ command.
// Ports:
//   CLK            system clock
//   RST_           asynchronous active-low reset
//   bus            aes_host_if_if.slave (pad and core signals)
//   dbg_state_o    current FSM state (0 IDLE, 1 PEND, 2 BUSY, 3 RESULT)
//   dbg_beat_cnt_o current beat counter
// BLK_W must be an integer multiple of BUS_W, with at least two beats per block.
// -----------------------------------------------------------------------------
module aes_host_if #(
  parameter  int BUS_W       = 8,
  parameter  int BLK_W       = 128,
  parameter  int SYNC_STAGES = 2,
  localparam int N           = BLK_W / BUS_W,
  localparam int CNT_W       = (N > 1) ? $clog2(N) : 1
) (
  input  logic             CLK,
  input  logic             RST_,
  aes_host_if_if.slave     bus,
  output logic [1:0]       dbg_state_o,
  output logic [CNT_W-1:0] dbg_beat_cnt_o
);

  localparam int                FILL_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PEND   = 2'd1,
    S_BUSY   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Pad synchronisers
  // ---------------------------------------------------------------------------
  logic [1:0]       cmd_sync_q [SYNC_STAGES];
  logic [BUS_W-1:0] din_sync_q [SYNC_STAGES];
  logic [FILL_W-1:0] fill_q;
  logic [1:0]       cmd_prev_q;

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        cmd_sync_q[i] <= '0;
        din_sync_q[i] <= '0;
      end
    end else begin
      cmd_sync_q[0] <= bus.CMD;
      din_sync_q[0] <= bus.DIN;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cmd_sync_q[i] <= cmd_sync_q[i-1];
        din_sync_q[i] <= din_sync_q[i-1];
      end
    end
  end

  logic [1:0]       cmd_s;
  logic [BUS_W-1:0] din_s;
  assign cmd_s = cmd_sync_q[SYNC_STAGES-1];
  assign din_s = din_sync_q[SYNC_STAGES-1];

  // The cleared sync flops would otherwise look like a genuine 00 from the pad.
  // That would fire a command held through reset. Until the pipeline holds
  // real pad samples, the previous-command register is parked at 11. This
  // blocks any strobe, so the host must show a real 00 first.
  logic fill_done;
  assign fill_done = (fill_q == FILL_MAX);

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      fill_q     <= '0;
      cmd_prev_q <= 2'b11;
    end else begin
      if (!fill_done) fill_q <= fill_q + FILL_W'(1);
      cmd_prev_q <= fill_done ? cmd_s : 2'b11;
    end
  end

  logic fire, fire_key, fire_text, fire_read;
  assign fire      = fill_done && (cmd_s != 2'b00) && (cmd_prev_q == 2'b00);
  assign fire_key  = fire && (cmd_s == 2'b01);
  assign fire_text = fire && (cmd_s == 2'b10);
  assign fire_read = fire && (cmd_s == 2'b11);

  // ---------------------------------------------------------------------------
  // FSM and datapath
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             type_q;       // type of the partial block: 0 key, 1 text
  logic [BLK_W-1:0] key_sr_q, text_sr_q, res_sr_q;
  logic [BLK_W-1:0] core_key_q, core_text_q;
  logic             core_key_vld_q, core_text_vld_q;
  logic             ready_q, ok_q;
  logic [BUS_W-1:0] dout_q;

  // A load of the other type while a partial block is open restarts at beat 0.
  logic [CNT_W-1:0] load_beat_d;
  logic             load_last_d;
  logic [BLK_W-1:0] key_shift_d, text_shift_d;

  assign load_beat_d  = ((beat_cnt_q != '0) && (type_q != fire_text)) ? '0 : beat_cnt_q;
  assign load_last_d  = (load_beat_d == LAST_BEAT);
  assign key_shift_d  = {key_sr_q[BLK_W-BUS_W-1:0], din_s};
  assign text_shift_d = {text_sr_q[BLK_W-BUS_W-1:0], din_s};

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      state_q         <= S_IDLE;
      beat_cnt_q      <= '0;
      type_q          <= 1'b0;
      key_sr_q        <= '0;
      text_sr_q       <= '0;
      res_sr_q        <= '0;
      core_key_q      <= '0;
      core_text_q     <= '0;
      core_key_vld_q  <= 1'b0;
      core_text_vld_q <= 1'b0;
      ready_q         <= 1'b1;
      ok_q            <= 1'b0;
      dout_q          <= '0;
    end else begin
      core_key_vld_q  <= 1'b0;
      core_text_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fire_key) begin
            key_sr_q <= key_shift_d;
            type_q   <= 1'b0;
            if (load_last_d) begin
              core_key_q     <= key_shift_d;
              core_key_vld_q <= 1'b1;
              beat_cnt_q     <= '0;
            end else begin
              beat_cnt_q <= load_beat_d + CNT_W'(1);
            end
          end else if (fire_text) begin
            text_sr_q <= text_shift_d;
            type_q    <= 1'b1;
            if (load_last_d) begin
              core_text_q <= text_shift_d;
              beat_cnt_q  <= '0;
              ready_q     <= 1'b0;
              state_q     <= S_PEND;
            end else begin
              beat_cnt_q <= load_beat_d + CNT_W'(1);
            end
          end
        end
        S_PEND: begin
          if (bus.core_ready) begin
            core_text_vld_q <= 1'b1;
            state_q         <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.core_res_vld) begin
            res_sr_q   <= bus.core_res;
            beat_cnt_q <= '0;
            ok_q       <= 1'b1;
            state_q    <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (fire_read) begin
            dout_q   <= res_sr_q[BLK_W-1 -: BUS_W];
            res_sr_q <= res_sr_q << BUS_W;
            if (beat_cnt_q == LAST_BEAT) begin
              beat_cnt_q <= '0;
              ok_q       <= 1'b0;
              ready_q    <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.READY         = ready_q;
  assign bus.OK            = ok_q;
  assign bus.DOUT          = dout_q;
  assign bus.core_key      = core_key_q;
  assign bus.core_key_vld  = core_key_vld_q;
  assign bus.core_text     = core_text_q;
  assign bus.core_text_vld = core_text_vld_q;

  assign dbg_state_o    = state_q;
  assign dbg_beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_aes_host_if.sv
// -----------------------------------------------------------------------------
// tb_aes_host_if
// Directed bench for aes_host_if (BUS_W=8, BLK_W=128, SYNC_STAGES=2).
// A vector table covers key loading and result readout. Hand-written sequences
// cover the stalled core, held commands, type switch and reset mid-read.
// -----------------------------------------------------------------------------
module tb_aes_host_if;

  localparam int BUS_W = 8;
  localparam int BLK_W = 128;
  localparam int SYNC  = 2;
  localparam int HOLD  = SYNC + 2;

  logic       CLK;
  logic       RST_;
  logic [1:0] dbg_state;
  logic [3:0] dbg_cnt;

  aes_host_if_if #(.BUS_W(BUS_W), .BLK_W(BLK_W)) bus ();

  aes_host_if #(.BUS_W(BUS_W), .BLK_W(BLK_W), .SYNC_STAGES(SYNC)) dut (
    .CLK            (CLK),
    .RST_           (RST_),
    .bus            (bus),
    .dbg_state_o    (dbg_state),
    .dbg_beat_cnt_o (dbg_cnt)
  );

  // clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // strobe pulse counters (cycles high)
  int key_pulses  = 0;
  int text_pulses = 0;
  always @(posedge CLK) begin
    if (bus.core_key_vld === 1'b1)  key_pulses  <= key_pulses + 1;
    if (bus.core_text_vld === 1'b1) text_pulses <= text_pulses + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [BLK_W-1:0] act,
                       input logic [BLK_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // One host beat: command and data together, hold, then return to NOP.
  task automatic send(input logic [1:0] cmd, input logic [7:0] din);
    bus.CMD = cmd;
    bus.DIN = din;
    tick(HOLD);
    bus.CMD = 2'b00;
    tick(HOLD);
  endtask

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_ready;
    logic       exp_ok;
  } vec_t;

  vec_t tbl [32];

  task automatic apply_tbl(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send(tbl[i].cmd, tbl[i].din);
      check($sformatf("vec%0d_dout", i),  BLK_W'(bus.DOUT),  BLK_W'(tbl[i].exp_dout));
      check($sformatf("vec%0d_ready", i), BLK_W'(bus.READY), BLK_W'(tbl[i].exp_ready));
      check($sformatf("vec%0d_ok", i),    BLK_W'(bus.OK),    BLK_W'(tbl[i].exp_ok));
    end
  endtask

  logic [BLK_W-1:0] res1, res2, exp_text;
  int k0, t0;

  initial begin
    res1 = 128'h112233445566778899AABBCCDDEEFF00;
    res2 = 128'h0123456789ABCDEFFEDCBA9876543210;

    // vectors 0..15: key beats 0x00..0x0F; DOUT still 0, READY 1, OK 0
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{cmd: 2'b01, din: 8'(i), exp_dout: 8'h00, exp_ready: 1'b1, exp_ok: 1'b0};
    end
    // vectors 16..31: READs of res1, hand-listed bytes
    begin
      logic [7:0] rb [16];
      rb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
             8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00};
      for (int i = 0; i < 16; i++) begin
        tbl[16+i] = '{cmd: 2'b11, din: 8'h00, exp_dout: rb[i],
                      exp_ready: (i == 15), exp_ok: (i != 15)};
      end
    end

    bus.CMD          = 2'b00;
    bus.DIN          = '0;
    bus.core_ready   = 1'b0;
    bus.core_res     = '0;
    bus.core_res_vld = 1'b0;
    RST_             = 1'b0;
    tick(3);

    // reset state
    check("rst_ready",    BLK_W'(bus.READY), 1);
    check("rst_ok",       BLK_W'(bus.OK), 0);
    check("rst_dout",     BLK_W'(bus.DOUT), 0);
    check("rst_key",      bus.core_key, 0);
    check("rst_text",     bus.core_text, 0);
    check("rst_key_vld",  BLK_W'(bus.core_key_vld), 0);
    check("rst_text_vld", BLK_W'(bus.core_text_vld), 0);
    check("rst_state",    BLK_W'(dbg_state), 0);
    RST_ = 1'b1;
    tick(HOLD);

    // key load
    k0 = key_pulses;
    apply_tbl(0, 15);
    tick(2);
    check("key_pulses", BLK_W'(key_pulses - k0), 1);
    check("core_key",   bus.core_key, 128'h000102030405060708090A0B0C0D0E0F);

    // text with core stalled
    t0 = text_pulses;
    for (int i = 0; i < 16; i++) send(2'b10, 8'hA0 + 8'(i));
    check("stall_ready",  BLK_W'(bus.READY), 0);
    check("stall_state",  BLK_W'(dbg_state), 1);
    check("stall_nopulse", BLK_W'(text_pulses - t0), 0);
    tick(5);
    check("stall_nopulse2", BLK_W'(text_pulses - t0), 0);
    bus.core_ready = 1'b1;
    tick(3);
    check("text_pulses", BLK_W'(text_pulses - t0), 1);
    check("core_text",   bus.core_text, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    check("busy_state",  BLK_W'(dbg_state), 2);
    bus.core_ready = 1'b0;

    // commands ignored in BUSY
    send(2'b01, 8'h77);
    check("busy_ignore", BLK_W'(dbg_cnt), 0);

    // result readout
    bus.core_res     = res1;
    bus.core_res_vld = 1'b1;
    tick(1);
    bus.core_res_vld = 1'b0;
    check("res_ok",    BLK_W'(bus.OK), 1);
    check("res_ready", BLK_W'(bus.READY), 0);
    apply_tbl(16, 31);
    check("read_done_state", BLK_W'(dbg_state), 0);

    // core_res_vld outside BUSY is ignored
    bus.core_res     = res2;
    bus.core_res_vld = 1'b1;
    tick(1);
    bus.core_res_vld = 1'b0;
    tick(1);
    check("stray_res_ok",    BLK_W'(bus.OK), 0);
    check("stray_res_state", BLK_W'(dbg_state), 0);

    // held command: one beat only
    bus.CMD = 2'b01;
    bus.DIN = 8'h5A;
    tick(20);
    bus.CMD = 2'b00;
    tick(HOLD);
    check("held_cnt", BLK_W'(dbg_cnt), 1);

    // type switch: 3 more key beats, then a full text block
    for (int i = 0; i < 3; i++) send(2'b01, 8'hB0 + 8'(i));
    check("partial_key_cnt", BLK_W'(dbg_cnt), 4);
    k0 = key_pulses;
    t0 = text_pulses;
    bus.core_ready = 1'b1;
    exp_text = '0;
    for (int i = 0; i < 16; i++) begin
      send(2'b10, 8'hC0 + 8'(i));
      exp_text = {exp_text[BLK_W-9:0], 8'hC0 + 8'(i)};
    end
    tick(2);
    bus.core_ready = 1'b0;
    check("switch_no_key", BLK_W'(key_pulses - k0), 0);
    check("switch_text_pulse", BLK_W'(text_pulses - t0), 1);
    check("switch_text", bus.core_text, exp_text);
    check("switch_key_kept", bus.core_key, 128'h000102030405060708090A0B0C0D0E0F);

    // reset mid-read
    bus.core_res     = res2;
    bus.core_res_vld = 1'b1;
    tick(1);
    bus.core_res_vld = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send(2'b11, 8'h00);
      check($sformatf("read2_%0d", i), BLK_W'(bus.DOUT), BLK_W'(res2[BLK_W-1-8*i -: 8]));
    end
    RST_ = 1'b0;
    #1;
    check("midrst_ok",    BLK_W'(bus.OK), 0);
    check("midrst_ready", BLK_W'(bus.READY), 1);
    check("midrst_dout",  BLK_W'(bus.DOUT), 0);
    tick(2);
    RST_ = 1'b1;
    tick(HOLD);
    send(2'b11, 8'h00);
    check("postrst_dout",  BLK_W'(bus.DOUT), 0);
    check("postrst_ok",    BLK_W'(bus.OK), 0);
    check("postrst_state", BLK_W'(dbg_state), 0);

    // command held through reset must not fire after release
    bus.CMD = 2'b01;
    bus.DIN = 8'h33;
    RST_ = 1'b0;
    tick(2);
    RST_ = 1'b1;
    tick(10);
    bus.CMD = 2'b00;
    tick(HOLD);
    check("held_thru_rst_cnt", BLK_W'(dbg_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
